// File: rtl/grostl_msg_loader_pkg.sv
// rtl/grostl_msg_loader_pkg.sv - shared types and constants for the Grostl message loader
package grostl_pkg;

   localparam int          WORDS_PER_BLK = 8;
   localparam logic [63:0] PAD_WORD      = 64'h8000_0000_0000_0000;

   typedef logic [63:0] len_t;

   typedef enum logic [1:0] {
      ST_FILL,
      ST_PAD,
      ST_OUT
   } state_t;

endpackage

// File: rtl/grostl_msg_loader_if.sv
// rtl/grostl_msg_loader_if.sv - word input stream and block output handshake bundle
interface grostl_msg_loader_if;

   logic [63:0]  din;
   logic         din_valid;
   logic         din_last;
   logic         din_ready;
   logic [511:0] blk_out;
   logic         blk_valid;
   logic         blk_final;
   logic         blk_ready;

   modport master (
      output din, din_valid, din_last, blk_ready,
      input  din_ready, blk_out, blk_valid, blk_final
   );

   modport slave (
      input  din, din_valid, din_last, blk_ready,
      output din_ready, blk_out, blk_valid, blk_final
   );

endinterface

// File: rtl/grostl_msg_loader.sv
// rtl/grostl_msg_loader.sv - packs 64-bit message words into padded 512-bit Grostl blocks
module grostl_msg_loader
   import grostl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   grostl_msg_loader_if.slave bus
);

   state_t       state_q, state_d;
   logic [2:0]   widx_q, widx_d;
   len_t         blk_cnt_q, blk_cnt_d;
   logic         pad_pend_q, pad_pend_d;
   logic         pad_done_q, pad_done_d;
   logic         final_q, final_d;
   logic [511:0] blk_q, blk_d;

   logic         wr_en;
   logic [63:0]  wr_word;

   always_comb begin
      state_d    = state_q;
      widx_d     = widx_q;
      blk_cnt_d  = blk_cnt_q;
      pad_pend_d = pad_pend_q;
      pad_done_d = pad_done_q;
      final_d    = final_q;
      blk_d      = blk_q;
      wr_en      = 1'b0;
      wr_word    = '0;

      case (state_q)
         ST_FILL: begin
            if (bus.din_valid) begin
               wr_en   = 1'b1;
               wr_word = bus.din;
               widx_d  = widx_q + 3'd1;
               if (widx_q == 3'd7) begin
                  state_d    = ST_OUT;
                  final_d    = 1'b0;
                  pad_pend_d = bus.din_last;
                  pad_done_d = 1'b0;
               end else if (bus.din_last) begin
                  state_d    = ST_PAD;
                  pad_done_d = 1'b0;
               end
            end
         end
         ST_PAD: begin
            wr_en  = 1'b1;
            widx_d = widx_q + 3'd1;
            if (!pad_done_q) begin
               wr_word    = PAD_WORD;
               pad_done_d = 1'b1;
               // Pad marker landed in the last slot: length must go in a fresh block.
               if (widx_q == 3'd7) begin
                  state_d    = ST_OUT;
                  final_d    = 1'b0;
                  pad_pend_d = 1'b1;
               end
            end else if (widx_q != 3'd7) begin
               wr_word = '0;
            end else begin
               wr_word = blk_cnt_q + len_t'(1);
               state_d = ST_OUT;
               final_d = 1'b1;
            end
         end
         ST_OUT: begin
            if (bus.blk_ready) begin
               blk_cnt_d = blk_cnt_q + len_t'(1);
               widx_d    = 3'd0;
               final_d   = 1'b0;
               if (final_q) begin
                  state_d    = ST_FILL;
                  blk_cnt_d  = '0;
                  pad_pend_d = 1'b0;
                  pad_done_d = 1'b0;
               end else if (pad_pend_q) begin
                  state_d    = ST_PAD;
                  pad_pend_d = 1'b0;
               end else begin
                  state_d = ST_FILL;
               end
            end
         end
         default: state_d = ST_FILL;
      endcase

      if (wr_en) begin
         for (int i = 0; i < WORDS_PER_BLK; i++) begin
            if (widx_q == i[2:0]) blk_d[511-64*i -: 64] = wr_word;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_FILL;
         widx_q     <= 3'd0;
         blk_cnt_q  <= '0;
         pad_pend_q <= 1'b0;
         pad_done_q <= 1'b0;
         final_q    <= 1'b0;
         blk_q      <= '0;
      end else begin
         state_q    <= state_d;
         widx_q     <= widx_d;
         blk_cnt_q  <= blk_cnt_d;
         pad_pend_q <= pad_pend_d;
         pad_done_q <= pad_done_d;
         final_q    <= final_d;
         blk_q      <= blk_d;
      end
   end

   assign bus.din_ready = (state_q == ST_FILL);
   assign bus.blk_valid = (state_q == ST_OUT);
   assign bus.blk_final = final_q & (state_q == ST_OUT);
   assign bus.blk_out   = blk_q;

endmodule

// File: tb/tb_grostl_msg_loader.sv
// tb/tb_grostl_msg_loader.sv - scoreboard bench for the Grostl message loader
module tb_grostl_msg_loader;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   grostl_msg_loader_if bus();

   grostl_msg_loader dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [511:0] blk;
      logic         fin;
   } exp_t;

   exp_t         exp_q[$];
   exp_t         cur;
   int           checks       = 0;
   int           failures     = 0;
   int           stall_cycles = 0;
   int           stall        = 0;
   int           blocks_seen  = 0;
   int           b0;
   bit           in_blk       = 0;
   logic [511:0] snap;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Block consumer: optional stall, stability check, then scoreboard pop.
   always @(negedge clk) begin
      bus.blk_ready = 1'b0;
      if (rst === 1'b1) begin
         in_blk = 0;
      end else if (bus.blk_valid === 1'b1) begin
         if (!in_blk) begin
            in_blk = 1;
            stall  = 0;
            snap   = bus.blk_out;
         end
         chk("din_ready_in_out", {511'd0, bus.din_ready}, 512'd0);
         if (stall > 0) chk("stall_stable", bus.blk_out, snap);
         if (stall < stall_cycles) begin
            stall++;
         end else begin
            if (exp_q.size() == 0) begin
               chk("unexpected_block", {511'd0, bus.blk_valid}, 512'd0);
            end else begin
               cur = exp_q.pop_front();
               chk("blk_out", bus.blk_out, cur.blk);
               chk("blk_final", {511'd0, bus.blk_final}, {511'd0, cur.fin});
            end
            bus.blk_ready = 1'b1;
            in_blk        = 0;
            blocks_seen++;
         end
      end
   end

   task automatic send_word(input logic [63:0] d, input logic last);
      int t = 0;
      bus.din       = d;
      bus.din_valid = 1'b1;
      bus.din_last  = last;
      while (bus.din_ready !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) chk("din_ready_timeout", {511'd0, bus.din_ready}, 512'd1);
      @(posedge clk);
      #1;
      bus.din_valid = 1'b0;
      bus.din_last  = 1'b0;
   endtask

   function automatic logic [63:0] data_word(input logic [63:0] seed, input int i);
      return seed + 64'(i) * 64'h1111_0000_0000_0001;
   endfunction

   // Reference padding: data, 0x80.., zeros up to slot 7 of a block, then block count.
   task automatic send_msg(input int n, input logic [63:0] seed);
      logic [63:0] w[$];
      exp_t        e;
      int          nb;
      for (int i = 0; i < n; i++) w.push_back(data_word(seed, i));
      w.push_back(64'h8000_0000_0000_0000);
      while (w.size() % 8 != 7) w.push_back(64'd0);
      nb = (w.size() + 1) / 8;
      w.push_back(64'(nb));
      for (int b = 0; b < nb; b++) begin
         e.blk = '0;
         for (int j = 0; j < 8; j++) e.blk[511-64*j -: 64] = w[b*8+j];
         e.fin = (b == nb - 1);
         exp_q.push_back(e);
      end
      for (int i = 0; i < n; i++) send_word(data_word(seed, i), i == n - 1);
   endtask

   task automatic wait_drain();
      int t = 0;
      while ((exp_q.size() != 0 || in_blk || bus.blk_valid === 1'b1) && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (t >= 500) chk("drain_timeout", 512'(exp_q.size()), 512'd0);
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog_timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      rst           = 1'b1;
      bus.din       = '0;
      bus.din_valid = 1'b0;
      bus.din_last  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_blk_valid", {511'd0, bus.blk_valid}, 512'd0);
      chk("rst_din_ready", {511'd0, bus.din_ready}, 512'd1);
      chk("rst_blk_final", {511'd0, bus.blk_final}, 512'd0);
      chk("rst_blk_out", bus.blk_out, 512'd0);
      rst = 1'b0;

      send_msg(1, 64'hDEAD_BEEF_0000_0001);
      wait_drain();
      send_msg(7, 64'hA5A5_0000_1234_0000);
      wait_drain();
      send_msg(8, 64'h0123_4567_89AB_CDEF);
      wait_drain();

      stall_cycles = 5;
      b0 = blocks_seen;
      send_msg(17, 64'hFEED_FACE_0000_0100);
      wait_drain();
      chk("blocks_17w", 512'(blocks_seen - b0), 512'd3);
      stall_cycles = 0;

      for (int i = 0; i < 4; i++) send_word(64'hBAD0_0000_0000_0000 + 64'(i), 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_blk_valid", {511'd0, bus.blk_valid}, 512'd0);
      chk("midrst_din_ready", {511'd0, bus.din_ready}, 512'd1);
      rst = 1'b0;
      send_msg(1, 64'h5555_0000_0000_0005);
      wait_drain();

      b0 = blocks_seen;
      send_msg(3, 64'h3333_0000_0000_0000);
      send_msg(2, 64'h2222_0000_0000_0000);
      wait_drain();
      chk("blocks_b2b", 512'(blocks_seen - b0), 512'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/grostl_msg_loader.md
GROSTL_MSG_LOADER -- requirements
Module: grostl_msg_loader

Interface
REQ-001 Clock/reset SHALL be: one clock `clk`; reset `rst`, synchronous, active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 din  input  64  message word, big-endian; byte 0 in din[63:56].
REQ-005 din_valid  input  1  din holds a valid word.
REQ-006 din_last  input  1  qualifies din as the final word of the message; whole 64-bit words only.
REQ-007 din_ready  output  1  loader accepts din this cycle.
REQ-008 blk_out  output  512  assembled block; word i at bits [511-64i -: 64], matching compression m_in column order.
REQ-009 blk_valid  output  1  blk_out holds a complete block.
REQ-010 blk_final  output  1  block is the last of the padded message; valid only with blk_valid.
REQ-011 blk_ready  input  1  downstream compression controller consumes the block.

Function
REQ-012 Transfers SHALL occur on din_valid&din_ready (input) and blk_valid&blk_ready (output).
REQ-013 States SHALL be FILL (din_ready=1), PAD (din_ready=0, internal word insertion), and OUT (blk_valid=1, din_ready=0).
REQ-014 FILL: each accepted word SHALL be written to slot widx (3-bit), then widx++.
- Accept at widx=7 -> OUT with blk_final=0; if din_last, set pad_pend.
- Accept with din_last at widx<7 -> PAD.
REQ-015 PAD SHALL write exactly one word per cycle to slot widx.
- Pad word 0x8000_0000_0000_0000 if not yet written.
- Else zero at widx<7.
- Else the length word at widx=7.
REQ-016 PAD: pad word written at widx=7 SHALL give OUT with blk_final=0 and pad_pend=1 (extra block needed). Length word written SHALL give OUT with blk_final=1.
REQ-017 Length word SHALL be the 64-bit total block count of the padded message, i.e. blk_cnt+1 when written.
REQ-018 OUT: on blk_ready, SHALL set blk_cnt++, widx=0, then go to:
- FILL with blk_cnt, pad flags cleared, if blk_final.
- PAD if pad_pend.
- FILL otherwise.
REQ-019 blk_out SHALL stay stable while blk_valid=1 and blk_ready=0; no input is accepted in OUT.
REQ-020 blk_valid SHALL assert the cycle after the slot-7 write; no combinational din->blk_valid path.
REQ-021 blk_cnt SHALL be 64 bits, wrapping modulo 2^64.
REQ-022 Zero-length messages are not supported; din_last SHALL always accompany a data word.
REQ-023 Slots not yet written in the current block SHALL be don't-care; every slot is written before OUT.

Reset
REQ-024 rst SHALL force, on the next edge:
- state=FILL, widx=0, blk_cnt=0, pad_pend=0, pad_done=0.
- Outputs: blk_valid=0, blk_final=0, din_ready=1 after reset.
REQ-025 rst mid-block or mid-PAD SHALL discard the partial block; the next accepted word starts a new message.
REQ-026 blk_out SHALL reset to all zeros.

Structure
REQ-027 grostl_pkg SHALL hold the state enum, WORDS_PER_BLK=8, PAD_WORD, and the width-64 length type.
REQ-028 No sub-module: a single FSM, a 512-bit block register, and a 64-bit counter.

Verification
REQ-029 The bench SHALL cover these scenarios:
- 1-word msg D: one block {D, 8000..0, 0×5, 0000_0000_0000_0001}, final=1.
- 7-word msg: block0 = D0..D6, 8000..0, final=0; block1 = 0×7, len 2, final=1.
- 8-word msg: block0 = data, final=0; block1 = {8000..0, 0×6, len 2}, final=1.
- 17-word msg with blk_ready held low 5 cycles per block: blk_out stable while stalled, din_ready=0 in OUT; 3 blocks out, last length word = 3.
- rst asserted at widx=4 mid-FILL: blk_valid=0 next cycle; new 1-word msg yields length word 1.
- Back-to-back messages: second message's length restarts at 1 (blk_cnt cleared after final).
